// File: rtl/drbg_keystream_buffer_if.sv
// Signal bundle between the DRBG, the sync parser and the keystream buffer.
// The master side drives the generator and sync flags; the slave side is the buffer.
interface drbg_keystream_buffer_if #(
  parameter int DATA_WIDTH_IN  = 256,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int DEPTH          = 2
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                      H;
  logic                      V;
  logic [DATA_WIDTH_IN-1:0]  data_in;
  logic                      data_in_valid;
  logic                      generator_busy;
  logic                      need_next;
  logic [DATA_WIDTH_OUT-1:0] data_out;
  logic                      data_out_valid;
  logic                      underflow;
  logic [LVL_W-1:0]          level;

  modport master (
    output H, V, data_in, data_in_valid, generator_busy,
    input  need_next, data_out, data_out_valid, underflow, level
  );

  modport slave (
    input  H, V, data_in, data_in_valid, generator_busy,
    output need_next, data_out, data_out_valid, underflow, level
  );
endinterface

// File: rtl/drbg_keystream_buffer.sv
// Buffers wide DRBG words and hands out one narrow chunk per active video line.
//   state   | meaning
//   IDLE    | no request outstanding; may request when a slot is free
//   WAIT    | request issued, waiting for data_in_valid
module drbg_keystream_buffer #(
  parameter int DATA_WIDTH_IN     = 256,
  parameter int DATA_WIDTH_OUT    = 8,
  parameter int DEPTH             = 2,
  parameter bit CONSUME_IN_VBLANK = 1'b0,
  parameter bit ALIGN_ON_FIELD    = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  drbg_keystream_buffer_if.slave bus
);
  localparam int CHUNKS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CI_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CI_W-1:0]  CI_LAST  = CI_W'(CHUNKS - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef logic [CHUNKS-1:0][DATA_WIDTH_OUT-1:0] word_t;

  word_t                     mem_q [DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CI_W-1:0]           ci_q, ci_d, ci_tick;
  logic [LVL_W-1:0]          level_q, level_d;
  logic [0:0]                state_q, state_d;
  logic                      h_q, v_q;
  logic                      need_next_q, need_next_d;
  logic [DATA_WIDTH_OUT-1:0] data_out_q, data_out_d;
  logic                      valid_q, valid_d;
  logic                      underflow_q, underflow_d;
  logic                      tick, v_fall, have_word, wr_en;
  logic                      pop_tick, pop_align, pop;

  always_comb begin
    tick      = bus.H & ~h_q & (~bus.V | CONSUME_IN_VBLANK);
    v_fall    = ~bus.V & v_q;
    have_word = (level_q != '0);
    wr_en     = (state_q == ST_WAIT) & bus.data_in_valid;

    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    underflow_d = underflow_q;
    ci_tick     = ci_q;
    pop_tick    = 1'b0;
    if (tick) begin
      if (have_word) begin
        data_out_d = mem_q[rd_ptr_q][ci_q];
        valid_d    = 1'b1;
        if (ci_q == CI_LAST) begin
          ci_tick  = '0;
          pop_tick = 1'b1;
        end else begin
          ci_tick  = ci_q + CI_W'(1);
        end
      end else begin
        underflow_d = 1'b1;
      end
    end

    // Field alignment acts on the chunk index left behind by a same-cycle tick.
    ci_d      = ci_tick;
    pop_align = 1'b0;
    if (ALIGN_ON_FIELD && v_fall && (ci_tick != '0) && have_word) begin
      ci_d      = '0;
      pop_align = 1'b1;
    end
    pop = pop_tick | pop_align;

    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    wr_ptr_d = wr_ptr_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);

    level_d = level_q;
    if (wr_en && !pop) level_d = level_q + LVL_W'(1);
    else if (!wr_en && pop) level_d = level_q - LVL_W'(1);

    state_d     = state_q;
    need_next_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if ((level_q < LVL_FULL) && !bus.generator_busy) begin
        state_d     = ST_WAIT;
        need_next_d = 1'b1;
      end
    end else if (bus.data_in_valid) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      ci_q        <= '0;
      level_q     <= '0;
      state_q     <= ST_IDLE;
      h_q         <= 1'b0;
      v_q         <= 1'b0;
      need_next_q <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      ci_q        <= ci_d;
      level_q     <= level_d;
      state_q     <= state_d;
      h_q         <= bus.H;
      v_q         <= bus.V;
      need_next_q <= need_next_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      underflow_q <= underflow_d;
    end
  end

  // Word storage carries no reset; occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.need_next      = need_next_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = valid_q;
  assign bus.underflow      = underflow_q;
  assign bus.level          = level_q;
endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// Self-checking bench: a queue-based model of the keystream buffer plus a
// generator responder, driven by directed scenarios and a randomized run.
module tb_drbg_keystream_buffer;
  localparam int DW_IN  = 256;
  localparam int DW_OUT = 8;
  localparam int DEPTH  = 2;
  localparam int CHUNKS = DW_IN / DW_OUT;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  drbg_keystream_buffer_if #(.DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .DEPTH(DEPTH)) b1 ();
  drbg_keystream_buffer_if #(.DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .DEPTH(DEPTH)) b2 ();

  drbg_keystream_buffer #(
    .DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .DEPTH(DEPTH),
    .CONSUME_IN_VBLANK(1'b0), .ALIGN_ON_FIELD(1'b1)
  ) dut (.clk(clk), .reset(reset), .bus(b1.slave));

  drbg_keystream_buffer #(
    .DATA_WIDTH_IN(DW_IN), .DATA_WIDTH_OUT(DW_OUT), .DEPTH(DEPTH),
    .CONSUME_IN_VBLANK(1'b1), .ALIGN_ON_FIELD(1'b1)
  ) dut_vb (.clk(clk), .reset(reset), .bus(b2.slave));

  assign b2.H              = b1.H;
  assign b2.V              = b1.V;
  assign b2.data_in        = b1.data_in;
  assign b2.data_in_valid  = b1.data_in_valid;
  assign b2.generator_busy = b1.generator_busy;

  int nvec = 0;
  int nfail = 0;

  // reference model (tracks dut / b1 only)
  logic [DW_IN-1:0]  mq[$];
  int                m_ci = 0;
  bit                m_uf = 0, m_out = 0, m_hp = 0, m_vp = 0;
  logic              exp_valid = 0, exp_need = 0;
  logic [DW_OUT-1:0] exp_data = '0;

  // generator responder / observation counters
  int          req_cnt = 0, vp1 = 0, vp2 = 0, resp_cd = 0, resp_lat = 10;
  bit          resp_en = 1, rand_words = 0, rand_lat = 0;
  logic [DW_IN-1:0] pat;

  function automatic logic [DW_IN-1:0] next_word();
    logic [DW_IN-1:0] w;
    if (!rand_words) return pat;
    for (int k = 0; k < DW_IN / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  // Advance one cycle: the model digests the edge just taken, then the
  // generator responder reacts to the DUT's request strobe.
  task automatic step();
    logic [DW_IN-1:0] w;
    bit tick;
    int sz;
    @(negedge clk);
    if (reset) begin
      mq.delete();
      m_ci = 0; m_uf = 0; m_out = 0; m_hp = 0; m_vp = 0;
      exp_valid = 0; exp_need = 0; exp_data = '0;
    end else begin
      sz = mq.size();
      exp_need  = !m_out && (sz < DEPTH) && !b1.generator_busy;
      exp_valid = 0;
      tick = b1.H && !m_hp && !b1.V;
      if (tick) begin
        if (sz > 0) begin
          w = mq[0];
          exp_data  = w[m_ci*DW_OUT +: DW_OUT];
          exp_valid = 1;
          m_ci++;
          if (m_ci == CHUNKS) begin m_ci = 0; void'(mq.pop_front()); end
        end else begin
          m_uf = 1;
        end
      end
      if (m_vp && !b1.V && m_ci != 0 && mq.size() > 0) begin
        void'(mq.pop_front());
        m_ci = 0;
      end
      if (b1.data_in_valid && m_out) begin mq.push_back(b1.data_in); m_out = 0; end
      if (exp_need) m_out = 1;
      m_hp = b1.H; m_vp = b1.V;
    end
    if (b1.data_out_valid) vp1++;
    if (b2.data_out_valid) vp2++;
    b1.data_in_valid = 1'b0;
    if (b1.need_next) begin
      req_cnt++;
      if (resp_en) resp_cd = rand_lat ? $urandom_range(1, 20) : resp_lat;
    end else if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0) begin
        b1.data_in = next_word();
        b1.data_in_valid = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    b1.H = 0; b1.V = 0; b1.data_in_valid = 0; b1.generator_busy = 0;
    resp_cd = 0;
    repeat (3) step();
    reset = 1'b0;
    req_cnt = 0; vp1 = 0; vp2 = 0;
  endtask

  task automatic wait_fill(output bit ok);
    int n = 0;
    while (b1.level !== LVL_W'(DEPTH) && n < 200) begin step(); n++; end
    ok = (n < 200);
  endtask

  task automatic test_reset();
    reset = 1'b1; resp_en = 1; resp_lat = 10; rand_words = 0; rand_lat = 0; resp_cd = 0;
    b1.generator_busy = 0;
    for (int i = 0; i < 4; i++) begin
      b1.H = 1'($urandom_range(0, 1)); b1.V = 1'($urandom_range(0, 1));
      step();
    end
    nvec++; if (b1.need_next !== 1'b0) begin nfail++; $display("FAIL reset_need_next got %b want 0", b1.need_next); end
    nvec++; if (b1.data_out !== 8'h00) begin nfail++; $display("FAIL reset_data_out got %h want 00", b1.data_out); end
    nvec++; if (b1.data_out_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b want 0", b1.data_out_valid); end
    nvec++; if (b1.underflow !== 1'b0) begin nfail++; $display("FAIL reset_underflow got %b want 0", b1.underflow); end
    nvec++; if (b1.level !== 2'd0) begin nfail++; $display("FAIL reset_level got %0d want 0", b1.level); end
    b1.H = 0; b1.V = 0; reset = 1'b0; req_cnt = 0;
    step();
    nvec++; if (b1.need_next !== 1'b1) begin nfail++; $display("FAIL first_request got %b want 1", b1.need_next); end
    repeat (40) step();
    nvec++; if (b1.level !== 2'd2) begin nfail++; $display("FAIL fill_level got %0d want 2", b1.level); end
    nvec++; if (req_cnt != 2) begin nfail++; $display("FAIL fill_requests got %0d want 2", req_cnt); end
  endtask

  task automatic test_line_ticks();
    vp1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 31) begin
        nvec++; if (req_cnt != 2) begin nfail++; $display("FAIL req_before_pop got %0d want 2", req_cnt); end
      end
      b1.H = 1; step();
      nvec++;
      if (b1.data_out_valid !== 1'b1 || b1.data_out !== 8'(i % 32) || b1.data_out !== exp_data) begin
        nfail++; $display("FAIL tick_%0d got valid=%b data=%h want valid=1 data=%h", i, b1.data_out_valid, b1.data_out, 8'(i % 32));
      end
      repeat ($urandom_range(0, 2)) step();
      b1.H = 0; repeat ($urandom_range(1, 4)) step();
    end
    nvec++; if (vp1 != 40) begin nfail++; $display("FAIL tick_pulses got %0d want 40", vp1); end
    nvec++; if (req_cnt != 3) begin nfail++; $display("FAIL third_request got %0d requests want 3", req_cnt); end
    repeat (20) step();
    nvec++; if (b1.level !== 2'd2) begin nfail++; $display("FAIL refill_level got %0d want 2", b1.level); end
  endtask

  task automatic test_underflow();
    do_reset();
    step();
    b1.generator_busy = 1;
    repeat (15) step();
    nvec++; if (b1.level !== 2'd1) begin nfail++; $display("FAIL busy_level got %0d want 1", b1.level); end
    vp1 = 0;
    for (int i = 0; i < 33; i++) begin
      b1.H = 1; step();
      if (i == 32) begin
        nvec++;
        if (b1.data_out_valid !== 1'b0 || b1.data_out !== 8'h1F || b1.underflow !== 1'b1 || m_uf != 1) begin
          nfail++; $display("FAIL underflow_tick got valid=%b data=%h uf=%b want 0/1f/1", b1.data_out_valid, b1.data_out, b1.underflow);
        end
      end
      b1.H = 0; step(); step();
    end
    nvec++; if (vp1 != 32) begin nfail++; $display("FAIL underflow_pulses got %0d want 32", vp1); end
    repeat (5) step();
    nvec++; if (req_cnt != 1 || b1.need_next !== 1'b0) begin nfail++; $display("FAIL busy_no_request got %0d requests want 1", req_cnt); end
    nvec++; if (b1.underflow !== 1'b1 || b1.data_out !== 8'h1F) begin nfail++; $display("FAIL underflow_sticky got uf=%b data=%h want 1/1f", b1.underflow, b1.data_out); end
    b1.generator_busy = 0;
    step(); step();
    nvec++; if (req_cnt != 2) begin nfail++; $display("FAIL busy_release got %0d requests want 2", req_cnt); end
  endtask

  task automatic test_vblank();
    bit ok;
    do_reset(); wait_fill(ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL vblank_fill timeout level=%0d want 2", b1.level); end
    b1.V = 1; step(); step();
    vp1 = 0; vp2 = 0;
    for (int i = 0; i < 20; i++) begin
      b1.H = 1; step(); b1.H = 0; step(); step();
    end
    nvec++; if (vp1 != 0) begin nfail++; $display("FAIL vblank_gated got %0d pulses want 0", vp1); end
    nvec++; if (vp2 != 20 || b2.data_out !== 8'h13) begin nfail++; $display("FAIL vblank_consume got %0d pulses data=%h want 20/13", vp2, b2.data_out); end
    b1.V = 0; step(); step();
    nvec++; if (b1.level !== 2'd2) begin nfail++; $display("FAIL align_ci0_nopop got level %0d want 2", b1.level); end
    b1.H = 1; step();
    nvec++; if (b1.data_out_valid !== 1'b1 || b1.data_out !== 8'h00) begin nfail++; $display("FAIL after_vblank got valid=%b data=%h want 1/00", b1.data_out_valid, b1.data_out); end
    b1.H = 0; step();
  endtask

  task automatic test_align();
    bit ok;
    do_reset(); wait_fill(ok);
    nvec++; if (!ok) begin nfail++; $display("FAIL align_fill timeout level=%0d want 2", b1.level); end
    for (int i = 0; i < 5; i++) begin
      b1.H = 1; step();
      nvec++; if (b1.data_out !== 8'(i) || b1.data_out_valid !== 1'b1) begin nfail++; $display("FAIL align_pre_%0d got %h want %h", i, b1.data_out, 8'(i)); end
      b1.H = 0; step(); step();
    end
    b1.V = 1; step(); step(); b1.V = 0; step();
    nvec++; if (b1.level !== 2'd1 || mq.size() != 1) begin nfail++; $display("FAIL align_pop got level %0d want 1", b1.level); end
    b1.H = 1; step();
    nvec++; if (b1.data_out_valid !== 1'b1 || b1.data_out !== 8'h00) begin nfail++; $display("FAIL align_next got valid=%b data=%h want 1/00", b1.data_out_valid, b1.data_out); end
    b1.H = 0; step();
    wait_fill(ok);
    b1.V = 1; step(); step();
    b1.V = 0; b1.H = 1; step();
    nvec++; if (b1.data_out_valid !== 1'b1 || b1.data_out !== 8'h01) begin nfail++; $display("FAIL tick_and_vfall got valid=%b data=%h want 1/01", b1.data_out_valid, b1.data_out); end
    nvec++; if (b1.level !== 2'd1) begin nfail++; $display("FAIL tick_and_vfall_pop got level %0d want 1", b1.level); end
    b1.H = 0; step(); b1.H = 1; step();
    nvec++; if (b1.data_out !== 8'h00 || b1.data_out !== exp_data) begin nfail++; $display("FAIL post_align got %h want 00", b1.data_out); end
    b1.H = 0; step();
  endtask

  task automatic test_write_tick_empty();
    logic [DW_IN-1:0] w;
    resp_en = 0;
    do_reset(); step(); step();
    w = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    b1.data_in = w; b1.data_in_valid = 1; b1.H = 1; step();
    nvec++; if (b1.data_out_valid !== 1'b0 || b1.underflow !== 1'b1) begin nfail++; $display("FAIL no_bypass got valid=%b uf=%b want 0/1", b1.data_out_valid, b1.underflow); end
    nvec++; if (b1.level !== 2'd1) begin nfail++; $display("FAIL no_bypass_level got %0d want 1", b1.level); end
    b1.H = 0; step(); b1.H = 1; step();
    nvec++; if (b1.data_out_valid !== 1'b1 || b1.data_out !== w[7:0]) begin nfail++; $display("FAIL stored_word got %h want %h", b1.data_out, w[7:0]); end
    b1.H = 0; step();
    resp_en = 1;
  endtask

  task automatic test_reset_mid_request();
    int r;
    resp_en = 0;
    do_reset(); step(); step();
    b1.generator_busy = 1; reset = 1; step(); step();
    reset = 0; r = req_cnt;
    step(); step();
    b1.data_in = next_word(); b1.data_in_valid = 1; step(); step();
    nvec++; if (b1.level !== 2'd0) begin nfail++; $display("FAIL late_valid_dropped got level %0d want 0", b1.level); end
    nvec++; if (req_cnt != r) begin nfail++; $display("FAIL no_request_while_busy got %0d want %0d", req_cnt, r); end
    b1.generator_busy = 0; step(); step();
    nvec++; if (req_cnt != r + 1) begin nfail++; $display("FAIL new_request got %0d want %0d", req_cnt, r + 1); end
    resp_en = 1;
  endtask

  task automatic test_random();
    do_reset();
    rand_words = 1; rand_lat = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) b1.H = ~b1.H;
      if ($urandom_range(0, 149) == 0) b1.V = ~b1.V;
      b1.generator_busy = ($urandom_range(0, 7) == 0);
      step();
      nvec++;
      if (b1.data_out_valid !== exp_valid || b1.data_out !== exp_data || b1.level !== LVL_W'(mq.size())
          || b1.underflow !== m_uf || b1.need_next !== exp_need) begin
        nfail++;
        $display("FAIL random_c%0d got v=%b d=%h l=%0d u=%b n=%b want v=%b d=%h l=%0d u=%b n=%b", c,
                 b1.data_out_valid, b1.data_out, b1.level, b1.underflow, b1.need_next,
                 exp_valid, exp_data, mq.size(), m_uf, exp_need);
      end
    end
    rand_words = 0; rand_lat = 0;
  endtask

  initial begin
    for (int k = 0; k < CHUNKS; k++) pat[k*8 +: 8] = 8'(k);
    b1.H = 0; b1.V = 0; b1.data_in = '0; b1.data_in_valid = 0; b1.generator_busy = 0;
    test_reset();
    test_line_ticks();
    test_underflow();
    test_vblank();
    test_align();
    test_write_tick_empty();
    test_reset_mid_request();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/drbg_keystream_buffer.md
# drbg_keystream_buffer

Parametrised keystream buffer between the double hash DRBG and the line scrambler: it requests wide random words from the generator, buffers up to `DEPTH` of them, and hands out one `DATA_WIDTH_OUT` chunk per video line, paced by the H/V flags from the sync parser. It generalises the single-word hash DRBG consumer with configurable width and depth, a vertical-blanking consumption mode, per-field chunk alignment, and underflow reporting.

## Interface
- `DATA_WIDTH_IN`, 256, generator word width; must be a multiple of `DATA_WIDTH_OUT`
- `DATA_WIDTH_OUT`, 8, chunk width delivered per line
- `DEPTH`, 2, number of generator words buffered (≥1)
- `CONSUME_IN_VBLANK`, 0, 1 = lines with V high also consume a chunk
- `ALIGN_ON_FIELD`, 1, 1 = discard a partially consumed head word at each field start
- `clk`  in  1  system clock (27 MHz pixel clock)
- `reset`  in  1  synchronous, active-high reset
- `H`  in  1  horizontal blanking flag from sync parser
- `V`  in  1  vertical blanking flag from sync parser
- `data_in`  in  DATA_WIDTH_IN  generator random word
- `data_in_valid`  in  1  one-cycle strobe qualifying `data_in`
- `generator_busy`  in  1  generator cannot accept a request
- `need_next`  out  1  one-cycle request for a new word
- `data_out`  out  DATA_WIDTH_OUT  current line's chunk, held until next pop
- `data_out_valid`  out  1  one-cycle strobe when `data_out` updates
- `underflow`  out  1  sticky: a line tick found the buffer empty
- `level`  out  $clog2(DEPTH+1)  words currently buffered

## Operation
- `CHUNKS = DATA_WIDTH_IN / DATA_WIDTH_OUT`; chunk k = `word[k*OUT +: OUT]`, LSB chunk first.
- Storage: circular buffer of `DEPTH` words, read/write pointers wrap modulo `DEPTH`, plus a chunk index `ci` (0..CHUNKS-1) into the head word.
- Line tick = rising edge of H (H high, previous H low) and (V low or `CONSUME_IN_VBLANK`).
- On tick with `level>0`: `data_out` ← chunk `ci` of head; `data_out_valid` pulses; `ci` increments; when `ci` wraps from CHUNKS-1 to 0, the head word is popped.
- On tick with `level==0`: `data_out` holds; no valid pulse; `underflow` set (cleared only by reset).
- Field alignment (`ALIGN_ON_FIELD=1`): on falling edge of V, if `ci≠0` and `level>0`, pop head word and clear `ci`; if `ci==0`, no action.
- Request FSM, states IDLE / WAIT:
  - IDLE → WAIT: `level < DEPTH`, `generator_busy` low; `need_next` pulses that cycle.
  - WAIT → IDLE: `data_in_valid`; word written at tail.
  - `data_in_valid` in IDLE is ignored (no write).
- Simultaneous write and pop in one cycle: both execute; `level` unchanged. Write into empty buffer and tick in the same cycle: tick sees empty → underflow (no bypass).
- Line tick and V falling edge in the same cycle: tick is processed first, then alignment applies to the resulting `ci`.
- Reset mid-request: FSM returns to IDLE; a late `data_in_valid` arriving in IDLE is dropped.

## Timing
- Reset values: `need_next=0`, `data_out=0`, `data_out_valid=0`, `underflow=0`, `level=0`, `ci=0`, FSM IDLE, edge-detect registers 0.
- H/V edge detection uses one register stage. `data_out`/`data_out_valid` update on the clock edge after the first cycle H is sampled high, i.e. 1 cycle after the tick.
- `need_next` is registered: asserted the cycle after the IDLE request condition holds; at most one outstanding request.
- `level` increments the cycle after `data_in_valid`; the first request after reset is issued 1 cycle after reset deasserts.
- Sustained rate: one chunk per line (1716 cycles), well below generator throughput; `DEPTH=2` hides one generator latency.

## Test plan
- Reset release, `generator_busy=0`, return `data_in=256'h…1F1E…0100` (byte k = k) 10 cycles after each request → `need_next` at cycle 1, `level` reaches 2, exactly 2 requests total.
- 40 line ticks with V low → `data_out` = 0x00,0x01,…,0x1F, then 0x00… from second word; exactly 40 `data_out_valid` pulses; third request after the 32nd tick.
- `generator_busy=1` held, 33 ticks after one word is loaded → tick 33 leaves `data_out=0x1F`, no pulse, `underflow=1`, `need_next` stays 0 until busy drops.
- `CONSUME_IN_VBLANK=0`, 20 H edges with V high → no valid pulses, `ci` unchanged; with `CONSUME_IN_VBLANK=1` → 20 pulses.
- `ALIGN_ON_FIELD=1`: 5 ticks, then V falls → head popped, next tick outputs byte 0x00 of second word; repeat with `ci=0` at V fall → no pop.
- `reset` asserted while FSM in WAIT, `data_in_valid` arrives 2 cycles after release → word dropped, `level=0`, new `need_next` issued.
